alu_pipe: RTL

//  Parametrised, 2-stage pipelined ALU; successor to the 8-bit combinational ALU.

---
 rtl/alu_pipe.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage pipelined ALU with barrel shift, ADC/SBC chaining and
// registered C/Z/N/V flags behind valid/ready handshakes.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_ready = !out_valid || out_ready
//   a, b              WIDTH-bit operands
//   alu_op            0 ADD 1 ADC 2 SUB 3 SBC 4 AND 5 OR 6 XOR 7 PASS_B
//   shift_op, shamt   0 none 1 SHL 2 SHR 3 ROR, amount 0..WIDTH-1
//   flag_clr          clear stored carry (wins over a stage-2 update)
//   out_valid/ready   output handshake
//   result            final post-shift result
//   cout/zout/nout/vout  carry (stored), zero, negative, signed overflow
module alu_pipe #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         alu_op,
  input  logic [1:0]         shift_op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flag_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               cout,
  output logic               zout,
  output logic               nout,
  output logic               vout
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADC  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SBC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  localparam logic [1:0] SH_NONE = 2'd0;
  localparam logic [1:0] SH_SHL  = 2'd1;
  localparam logic [1:0] SH_SHR  = 2'd2;
  localparam logic [1:0] SH_ROR  = 2'd3;

  // stage 1 registers
  logic               r_s1_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [1:0]         r_sh;
  logic [SHAMT_W-1:0] r_shamt;

  // stage 2 registers
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_z;
  logic               r_n;
  logic               r_v;

  // datapath wires
  logic               w_adv;
  logic               w_is_sub;
  logic [WIDTH-1:0]   w_bx;
  logic               w_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_r;
  logic               w_ac;
  logic               w_v;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [SHAMT_W:0]   w_lsh;
  logic [WIDTH-1:0]   w_rot;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_sh       <= '0;
      r_shamt    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_op    <= alu_op;
        r_sh    <= shift_op;
        r_shamt <= shamt;
      end
    end
  end

  // Subtraction is a + ~b + cin, so C=1 means no borrow.
  assign w_is_sub = (r_op == OP_SUB) || (r_op == OP_SBC);
  assign w_bx     = w_is_sub ? ~r_b : r_b;

  always_comb begin
    w_cin = 1'b0;
    unique case (r_op)
      OP_ADC:  w_cin = r_carry;
      OP_SUB:  w_cin = 1'b1;
      OP_SBC:  w_cin = r_carry;
      default: w_cin = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, r_a} + {1'b0, w_bx}
               + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_r  = w_sum[WIDTH-1:0];
    w_ac = 1'b0;
    w_v  = 1'b0;
    unique case (r_op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        w_r  = w_sum[WIDTH-1:0];
        w_ac = w_sum[WIDTH];
        w_v  = (r_a[WIDTH-1] == w_bx[WIDTH-1])
            && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      OP_AND:  w_r = r_a & r_b;
      OP_OR:   w_r = r_a | r_b;
      OP_XOR:  w_r = r_a ^ r_b;
      OP_PASS: w_r = r_b;
      default: w_r = r_b;
    endcase
  end

  // One extra bit on each shifter catches the last bit shifted out.
  assign w_shl = {1'b0, w_r} << r_shamt;
  assign w_shr = {w_r, 1'b0} >> r_shamt;
  assign w_lsh = (SHAMT_W+1)'(WIDTH) - {1'b0, r_shamt};
  assign w_rot = (w_r >> r_shamt) | (w_r << w_lsh);

  always_comb begin
    w_res = w_r;
    w_c   = w_ac;
    if (r_shamt != '0) begin
      unique case (r_sh)
        SH_SHL: begin
          w_res = w_shl[WIDTH-1:0];
          w_c   = w_shl[WIDTH];
        end
        SH_SHR: begin
          w_res = w_shr[WIDTH:1];
          w_c   = w_shr[0];
        end
        SH_ROR: begin
          w_res = w_rot;
          w_c   = w_rot[WIDTH-1];
        end
        SH_NONE: begin
          w_res = w_r;
          w_c   = w_ac;
        end
        default: begin
          w_res = w_r;
          w_c   = w_ac;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      if (w_adv) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_adv && r_s1_valid) begin
        r_result <= w_res;
        r_carry  <= w_c;
        r_z      <= (w_res == '0);
        r_n      <= w_res[WIDTH-1];
        r_v      <= w_v;
      end
      // last assignment wins: a clear beats a same-edge update
      if (flag_clr) begin
        r_carry <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign cout      = r_carry;
  assign zout      = r_z;
  assign nout      = r_n;
  assign vout      = r_v;

endmodule
